// File: rtl/alu_mdu.sv
// alu_mdu: handshaked single-cycle ALU with an iterative multiply/divide unit.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid / in_ready  operation handshake (accepted when both are high)
//   a, b                 operands (shifts: a = amount, b = data)
//   alu_fun, sign        ALU function and signedness of overflow/compare
//   md_en, md_op         MDU select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   out_valid / out_ready result handshake; outputs held until consumed
//   z                    ALU result; hi, lo MDU result pair
//   ovf, zero            add/sub overflow, z==0 flag
//   busy                 MDU iterating
// Config macro ALU_MDU_DIV_EN: when defined, DIV/DIVU run on an iterative
//   restoring divider; when undefined, they finish in one cycle with hi=lo=0.
module alu_mdu #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alu_fun,
  input  logic             sign,
  input  logic             md_en,
  input  logic [1:0]       md_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

`ifdef ALU_MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif
  localparam logic [SHAMT_W-1:0] LastCnt = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
  logic               neg_res_q, neg_res_d;
`ifdef ALU_MDU_DIV_EN
  logic               is_div_q, is_div_d, neg_a_q, neg_a_d, div0_q, div0_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     div_shift_c;
`endif
  logic [WIDTH-1:0]   z_q, z_d, hi_q, hi_d, lo_q, lo_d;
  logic               ovf_q, ovf_d, zero_q, zero_d;
  logic               out_valid_q, out_valid_d, busy_q, busy_d, in_ready_q, in_ready_d;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign z         = z_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Single-cycle ALU datapath
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   alu_z_c;
  logic               alu_ovf_c;
  logic [SHAMT_W-1:0] shamt_c;

  always_comb begin
    alu_z_c   = '0;
    alu_ovf_c = 1'b0;
    add_w     = {1'b0, a} + {1'b0, b};
    sub_w     = {1'b0, a} - {1'b0, b};
    shamt_c   = a[SHAMT_W-1:0];
    case (alu_fun[5:4])
      2'b00: begin
        if (alu_fun[0]) begin
          alu_z_c   = sub_w[WIDTH-1:0];
          alu_ovf_c = sign ? ((a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]))
                           : sub_w[WIDTH];
        end else begin
          alu_z_c   = add_w[WIDTH-1:0];
          alu_ovf_c = sign ? ((a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]))
                           : add_w[WIDTH];
        end
      end
      2'b01: begin
        case (alu_fun[3:0])
          4'b1000: alu_z_c = a & b;
          4'b1110: alu_z_c = a | b;
          4'b0110: alu_z_c = a ^ b;
          4'b0001: alu_z_c = ~(a | b);
          4'b1010: alu_z_c = a;
          default: alu_z_c = '0;
        endcase
      end
      2'b10: begin
        case (alu_fun[1:0])
          2'b00:   alu_z_c = b << shamt_c;
          2'b01:   alu_z_c = b >> shamt_c;
          2'b11:   alu_z_c = WIDTH'($signed(b) >>> shamt_c);
          default: alu_z_c = '0;
        endcase
      end
      default: begin
        case (alu_fun[3:1])
          3'b001:  alu_z_c = WIDTH'(a == b);
          3'b000:  alu_z_c = WIDTH'(a != b);
          3'b010:  alu_z_c = sign ? WIDTH'($signed(a) < $signed(b)) : WIDTH'(a < b);
          3'b110:  alu_z_c = WIDTH'(a[WIDTH-1] || (a == '0));
          3'b101:  alu_z_c = WIDTH'(a[WIDTH-1]);
          3'b111:  alu_z_c = WIDTH'(!a[WIDTH-1] && (a != '0));
          default: alu_z_c = '0;
        endcase
      end
    endcase
  end

  // MDU runs on magnitudes; sign is restored on the final step
  logic             md_iter_c, md_signed_c, neg_a_c, neg_b_c;
  logic [WIDTH-1:0] mag_a_c, mag_b_c;

  assign md_iter_c   = md_en && (DivEn || !md_op[1]);
  assign md_signed_c = !md_op[0];
  assign neg_a_c     = md_signed_c && a[WIDTH-1];
  assign neg_b_c     = md_signed_c && b[WIDTH-1];
  assign mag_a_c     = neg_a_c ? ('0 - a) : a;
  assign mag_b_c     = neg_b_c ? ('0 - b) : b;

  // One shift-add multiply step or one restoring divide step
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] step_hi_c, step_lo_c;

  always_comb begin
    mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
    step_hi_c = mul_sum_c[WIDTH:1];
    step_lo_c = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
    div_shift_c = {acc_hi_q, acc_lo_q[WIDTH-1]};
    if (is_div_q) begin
      if (div_shift_c >= {1'b0, opb_q}) begin
        step_hi_c = WIDTH'(div_shift_c - {1'b0, opb_q});
        step_lo_c = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi_c = div_shift_c[WIDTH-1:0];
        step_lo_c = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  // Final sign correction and divide special cases
  logic [2*WIDTH-1:0] prod_c;
  logic [WIDTH-1:0]   mdu_hi_c, mdu_lo_c;

  always_comb begin
    prod_c   = neg_res_q ? ('0 - {step_hi_c, step_lo_c}) : {step_hi_c, step_lo_c};
    mdu_hi_c = prod_c[2*WIDTH-1:WIDTH];
    mdu_lo_c = prod_c[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    if (is_div_q) begin
      if (div0_q) begin
        mdu_lo_c = '1;
        mdu_hi_c = a_q;
      end else begin
        mdu_lo_c = neg_res_q ? ('0 - step_lo_c) : step_lo_c;
        mdu_hi_c = neg_a_q   ? ('0 - step_hi_c) : step_hi_c;
      end
    end
`endif
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    opb_d       = opb_q;
    neg_res_d   = neg_res_q;
`ifdef ALU_MDU_DIV_EN
    is_div_d    = is_div_q;
    neg_a_d     = neg_a_q;
    div0_d      = div0_q;
    a_d         = a_q;
`endif
    z_d         = z_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          if (md_iter_c) begin
            state_d   = S_BUSY;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_hi_d  = '0;
            acc_lo_d  = mag_a_c;
            opb_d     = mag_b_c;
            neg_res_d = neg_a_c ^ neg_b_c;
`ifdef ALU_MDU_DIV_EN
            is_div_d  = md_op[1];
            neg_a_d   = neg_a_c;
            div0_d    = (b == '0);
            a_d       = a;
`endif
          end else begin
            // ALU op, or a divide when the divider is not built
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            z_d         = md_en ? '0 : alu_z_c;
            ovf_d       = !md_en && alu_ovf_c;
            zero_d      = !md_en && (alu_z_c == '0);
            hi_d        = '0;
            lo_d        = '0;
          end
        end
      end
      S_BUSY: begin
        acc_hi_d = step_hi_c;
        acc_lo_d = step_lo_c;
        cnt_d    = cnt_q + SHAMT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d     = S_DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          z_d         = '0;
          ovf_d       = 1'b0;
          zero_d      = 1'b0;
          hi_d        = mdu_hi_c;
          lo_d        = mdu_lo_c;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      opb_q       <= '0;
      neg_res_q   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      div0_q      <= 1'b0;
      a_q         <= '0;
`endif
      z_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      opb_q       <= opb_d;
      neg_res_q   <= neg_res_d;
`ifdef ALU_MDU_DIV_EN
      is_div_q    <= is_div_d;
      neg_a_q     <= neg_a_d;
      div0_q      <= div0_d;
      a_q         <= a_d;
`endif
      z_q         <= z_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized self-checking bench for alu_mdu against an
// arithmetic reference model (64-bit integer math on the operation rules).
module tb_alu_mdu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, sign, md_en, out_valid, out_ready;
  logic         ovf, zero, busy;
  logic [W-1:0] a, b, z, hi, lo;
  logic [5:0]   alu_fun;
  logic [1:0]   md_op;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] last_z, last_hi, last_lo;
  logic         last_ovf;

  typedef struct packed {
    logic [W-1:0] z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    logic         zero;
    logic [7:0]   lat;
  } exp_t;

  alu_mdu #(.WIDTH(W), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_fun(alu_fun), .sign(sign), .md_en(md_en), .md_op(md_op),
    .out_valid(out_valid), .out_ready(out_ready), .z(z), .hi(hi), .lo(lo),
    .ovf(ovf), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: results from integer arithmetic on the operation rules
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic [5:0] fun, input logic sgn,
                                 input logic md, input logic [1:0] op);
    exp_t        e;
    longint      sa, sb, r;
    logic [63:0] p;
    int          amt;
    e   = '0;
    e.lat = 8'd1;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    amt = int'(ma[4:0]);
    if (md) begin
      if (!op[1]) begin
        e.lat = 8'(W + 1);
        if (op[0]) p = {32'b0, ma} * {32'b0, mb};
        else       p = 64'(sa * sb);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end else begin
`ifdef ALU_MDU_DIV_EN
        e.lat = 8'(W + 1);
        if (mb == '0) begin
          e.lo = '1;
          e.hi = ma;
        end else if (op[0]) begin
          e.lo = ma / mb;
          e.hi = ma % mb;
        end else begin
          e.lo = 32'(sa / sb);
          e.hi = 32'(sa % sb);
        end
`endif
      end
      return e;
    end
    case (fun[5:4])
      2'b00: begin
        if (fun[0]) begin
          r     = sa - sb;
          e.z   = ma - mb;
          e.ovf = sgn ? (r != longint'($signed(e.z))) : (ma < mb);
        end else begin
          r     = sa + sb;
          e.z   = ma + mb;
          p     = {32'b0, ma} + {32'b0, mb};
          e.ovf = sgn ? (r != longint'($signed(e.z))) : (p > 64'hFFFF_FFFF);
        end
      end
      2'b01: begin
        case (fun[3:0])
          4'b1000: e.z = ma & mb;
          4'b1110: e.z = ma | mb;
          4'b0110: e.z = ma ^ mb;
          4'b0001: e.z = ~(ma | mb);
          4'b1010: e.z = ma;
          default: e.z = '0;
        endcase
      end
      2'b10: begin
        case (fun[1:0])
          2'b00:   e.z = mb << amt;
          2'b01:   e.z = mb >> amt;
          2'b11:   e.z = 32'($signed(mb) >>> amt);
          default: e.z = '0;
        endcase
      end
      default: begin
        case (fun[3:1])
          3'b001:  e.z = {31'b0, ma == mb};
          3'b000:  e.z = {31'b0, ma != mb};
          3'b010:  e.z = {31'b0, sgn ? (sa < sb) : (ma < mb)};
          3'b110:  e.z = {31'b0, sa <= 0};
          3'b101:  e.z = {31'b0, sa < 0};
          3'b111:  e.z = {31'b0, sa > 0};
          default: e.z = '0;
        endcase
      end
    endcase
    e.zero = (e.z == '0);
    return e;
  endfunction

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [5:0] fun, input logic sgn,
                        input logic md, input logic [1:0] op, input int hold);
    exp_t e;
    int   lat;
    e = model(ia, ib, fun, sgn, md, op);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ia; b = ib; alu_fun = fun; sign = sgn; md_en = md; md_op = op;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Scramble inputs: the op in flight must use the captured operands
    in_valid = 1'b0;
    a = $urandom; b = $urandom; alu_fun = 6'($urandom);
    sign = 1'($urandom); md_en = 1'($urandom); md_op = 2'($urandom);
    check("in_ready_after_accept", in_ready, 0);
    check("busy_after_accept", busy, W'(e.lat > 8'd1));
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", W'(lat), W'(e.lat));
    if (!out_valid) return;
    check("z", z, e.z);
    check("hi", hi, e.hi);
    check("lo", lo, e.lo);
    check("ovf", ovf, e.ovf);
    check("zero", zero, e.zero);
    check("busy_done", busy, 0);
    last_z = z; last_hi = hi; last_lo = lo; last_ovf = ovf;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_z", z, e.z);
      check("hold_hi", hi, e.hi);
      check("hold_lo", lo, e.lo);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_valid", out_valid, 0);
    check("drain_ready", in_ready, 1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] edges [6];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  logic [5:0] funs [16];

  initial begin
    funs = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
             6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110010, 6'b110000,
             6'b110100, 6'b111100, 6'b111010, 6'b111110};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_fun = '0; sign = 1'b0; md_en = 1'b0; md_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_z", z, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_ovf", ovf, 0);
    check("rst_zero", zero, 0);

    // Directed cases
    run_op(32'h7FFF_FFFF, 32'h1, 6'b000000, 1'b1, 1'b0, 2'b00, 5);
    check("add_s_z", last_z, 32'h8000_0000);
    check("add_s_ovf", last_ovf, 1);
    run_op(32'h7FFF_FFFF, 32'h1, 6'b000000, 1'b0, 1'b0, 2'b00, 0);
    check("add_u_ovf", last_ovf, 0);
    run_op(32'h4, 32'hF000_0000, 6'b100011, 1'b0, 1'b0, 2'b00, 0);
    check("sra_z", last_z, 32'hFF00_0000);
    run_op(32'hFFFF_FFFF, 32'h1, 6'b110101, 1'b1, 1'b0, 2'b00, 0);
    check("lt_s_z", last_z, 32'h1);
    run_op(32'hFFFF_FFFF, 32'h1, 6'b110101, 1'b0, 1'b0, 2'b00, 0);
    check("lt_u_z", last_z, 32'h0);
    run_op(32'hFFFF_FFFE, 32'h3, 6'b000000, 1'b0, 1'b1, 2'b00, 2);
    check("mult_hi", last_hi, 32'hFFFF_FFFF);
    check("mult_lo", last_lo, 32'hFFFF_FFFA);
    run_op(32'hFFFF_FFF9, 32'h2, 6'b000000, 1'b0, 1'b1, 2'b10, 0);
    run_op(32'h5, 32'h0, 6'b000000, 1'b0, 1'b1, 2'b11, 0);
`ifdef ALU_MDU_DIV_EN
    check("divu0_lo", last_lo, 32'hFFFF_FFFF);
    check("divu0_hi", last_hi, 32'h5);
`else
    check("divu0_lo", last_lo, 32'h0);
    check("divu0_hi", last_hi, 32'h0);
`endif
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 6'b000000, 1'b0, 1'b1, 2'b10, 0);
    run_op(32'h8000_0000, 32'h8000_0000, 6'b000000, 1'b0, 1'b1, 2'b00, 0);

    // Reset in the middle of a multiply
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; md_en = 1'b1; md_op = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    repeat (40) begin
      @(negedge clk);
      if (out_valid) break;
    end
    check("midrst_no_result", out_valid, 0);

    // Randomized mix of ALU and MDU operations
    for (int i = 0; i < 200; i++) begin
      logic [5:0] f;
      logic       md;
      f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : funs[$urandom_range(0, 15)];
      md = ($urandom_range(0, 2) == 0);
      run_op(rnd_operand(), rnd_operand(), f, 1'($urandom), md, 2'($urandom),
             $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
